// File: rtl/vga_menu_pkg.sv
// Shared constants, FSM encoding and coordinate helper for the VGA menu renderer.
package vga_menu_pkg;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned GLYPH_W      = 21;
  localparam int unsigned GLYPH_H      = 25;
  localparam int unsigned GLYPH_STRIDE = 525;
  localparam int unsigned LOGO_X0      = 204;
  localparam int unsigned LOGO_X1      = 435;
  localparam int unsigned LOGO_Y0      = 40;
  localparam int unsigned LOGO_Y1      = 196;
  localparam int unsigned OPT_X0       = 133;
  localparam int unsigned OPT_DX       = 227;
  localparam int unsigned OPT_Y0       = 227;
  localparam int unsigned OPT_DY       = 58;
  localparam int unsigned CURSOR_PAD   = 3;

  localparam logic [18:0] FONT_BASE    = 19'd307200;
  localparam logic [18:0] LOGO_BASE    = 19'd25940;
  localparam logic [18:0] BLANK_ADDR   = 19'd1923;
  localparam logic [7:0]  BORDER_INDEX = 8'd7;
  localparam logic [5:0]  BLANK_GLYPH  = 6'd63;

  typedef enum logic {NAV_IDLE, NAV_LOCK} nav_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } cart_t;

  function automatic cart_t addr_to_cart(input logic [18:0] addr);
    cart_t c;
    c.x = 10'(addr % 19'(SCREEN_W));
    c.y = 10'(addr / 19'(SCREEN_W));
    return c;
  endfunction

endpackage

// File: rtl/vga_menu_nav.sv
// Menu selection FSM with cursor blink counter and post-confirm input lock.
module vga_menu_nav
  import vga_menu_pkg::*;
#(
  parameter int unsigned NUM_OPTS     = 5,
  parameter int unsigned OPT_ROWS     = 3,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned LOCK_FRAMES  = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_sel,
  output logic [2:0] sel,
  output logic       sel_done,
  output logic       blink_on
);

  localparam int unsigned BW = $clog2(2 * BLINK_FRAMES);
  localparam int unsigned LW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_ON   = BW'(BLINK_FRAMES);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FRAMES - 1);

  nav_state_t    state, state_n;
  logic [2:0]    sel_n;
  logic          done_n;
  logic [BW-1:0] blink_cnt, blink_n;
  logic [LW-1:0] lock_cnt, lock_n;
  logic [4:0]    cur, row, base, tgt;
  logic          move;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= NAV_IDLE;
      sel       <= '0;
      sel_done  <= 1'b0;
      blink_cnt <= '0;
      lock_cnt  <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      sel_done  <= done_n;
      blink_cnt <= blink_n;
      lock_cnt  <= lock_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    done_n  = 1'b0;
    blink_n = blink_cnt;
    lock_n  = lock_cnt;
    cur     = {2'b00, sel};
    row     = cur % 5'(OPT_ROWS);
    base    = cur - row;
    tgt     = cur;
    move    = 1'b0;

    if (frame_tick)
      blink_n = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);

    // Vertical moves wrap within the column; out-of-range targets are dropped below.
    if (key_up) begin
      tgt  = (row == 5'd0) ? base + 5'(OPT_ROWS - 1) : cur - 5'd1;
      move = 1'b1;
    end else if (key_down) begin
      tgt  = (row == 5'(OPT_ROWS - 1)) ? base : cur + 5'd1;
      move = 1'b1;
    end else if (key_left) begin
      tgt  = cur - 5'(OPT_ROWS);
      move = (cur >= 5'(OPT_ROWS));
    end else if (key_right) begin
      tgt  = cur + 5'(OPT_ROWS);
      move = 1'b1;
    end

    case (state)
      NAV_IDLE: begin
        if (key_sel) begin
          done_n  = 1'b1;
          state_n = NAV_LOCK;
          lock_n  = '0;
        end else if (move && (tgt < 5'(NUM_OPTS))) begin
          sel_n   = tgt[2:0];
          blink_n = '0;
        end
      end
      NAV_LOCK: begin
        if (frame_tick) begin
          if (lock_cnt == LOCK_LAST) begin
            state_n = NAV_IDLE;
            lock_n  = '0;
          end else begin
            lock_n = lock_cnt + LW'(1);
          end
        end
      end
      default: state_n = NAV_IDLE;
    endcase
  end

  assign blink_on = (blink_cnt < BLINK_ON);

endmodule

// File: rtl/vga_menu_renderer.sv
// Three-stage pixel pipeline: ROM address/overlay decode, ROM return alignment, colour select.
module vga_menu_renderer
  import vga_menu_pkg::*;
#(
  parameter int unsigned NUM_OPTS     = 5,
  parameter int unsigned OPT_ROWS     = 3,
  parameter int unsigned OPT_CHARS    = 7,
  parameter logic [NUM_OPTS*OPT_CHARS*6-1:0] OPT_TEXT = '1,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned LOCK_FRAMES  = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [18:0] pix_addr,
  input  logic        pix_valid,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_sel,
  input  logic [7:0]  index_in,
  output logic [18:0] addr_to_read,
  output logic        addr_valid,
  output logic [7:0]  index_out,
  output logic        index_valid,
  output logic [2:0]  sel,
  output logic        sel_done
);

  localparam logic [18:0] G_W      = 19'(GLYPH_W);
  localparam logic [18:0] G_H      = 19'(GLYPH_H);
  localparam logic [18:0] G_STRIDE = 19'(GLYPH_STRIDE);
  localparam logic [18:0] PAD      = 19'(CURSOR_PAD);
  localparam logic [18:0] TEXT_W   = 19'(OPT_CHARS * GLYPH_W);
  localparam logic [18:0] CUR_W    = 19'(OPT_CHARS * GLYPH_W + 2 * CURSOR_PAD);
  localparam logic [18:0] CUR_H    = 19'(GLYPH_H + 2 * CURSOR_PAD);
  localparam logic [18:0] EDGE_LO  = 19'd3;
  localparam logic [18:0] EDGE_XHI = 19'(SCREEN_W - 4);
  localparam logic [18:0] EDGE_YHI = 19'(SCREEN_H - 4);

  cart_t       cart;
  logic [18:0] px, py, ox, oy, gx, addr_n;
  logic [5:0]  glyph;
  logic        border_hit, cursor_hit, in_outer, in_inner;
  logic        blink_on, frame_tick;
  logic        ovl1, ovl2, valid2;

  assign frame_tick = pix_valid && (pix_addr == '0);
  assign cart       = addr_to_cart(pix_addr);
  assign px         = 19'(cart.x);
  assign py         = 19'(cart.y);

  vga_menu_nav #(
    .NUM_OPTS     (NUM_OPTS),
    .OPT_ROWS     (OPT_ROWS),
    .BLINK_FRAMES (BLINK_FRAMES),
    .LOCK_FRAMES  (LOCK_FRAMES)
  ) u_nav (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_sel    (key_sel),
    .sel        (sel),
    .sel_done   (sel_done),
    .blink_on   (blink_on)
  );

  // Offsets are only formed after the region test passes, so subtractions never wrap.
  always_comb begin
    addr_n     = BLANK_ADDR;
    cursor_hit = 1'b0;
    ox         = '0;
    oy         = '0;
    gx         = '0;
    glyph      = BLANK_GLYPH;
    in_outer   = 1'b0;
    in_inner   = 1'b0;
    border_hit = (px < EDGE_LO) || (px > EDGE_XHI) || (py < EDGE_LO) || (py > EDGE_YHI);

    if (px >= 19'(LOGO_X0) && px < 19'(LOGO_X1) && py >= 19'(LOGO_Y0) && py < 19'(LOGO_Y1))
      addr_n = LOGO_BASE + (px - 19'(LOGO_X0)) + (py - 19'(LOGO_Y0)) * 19'(SCREEN_W);

    for (int unsigned i = 0; i < NUM_OPTS; i++) begin
      ox = 19'(OPT_X0 + (i / OPT_ROWS) * OPT_DX);
      oy = 19'(OPT_Y0 + (i % OPT_ROWS) * OPT_DY);
      for (int unsigned k = 0; k < OPT_CHARS; k++) begin
        gx = ox + 19'(k * GLYPH_W);
        if (px >= gx && px < gx + G_W && py >= oy && py < oy + G_H) begin
          glyph = OPT_TEXT[(i*OPT_CHARS+k)*6 +: 6];
          if (glyph != BLANK_GLYPH)
            addr_n = FONT_BASE + G_STRIDE * {13'd0, glyph} + (px - gx) + G_W * (py - oy);
        end
      end
      in_outer = px >= ox - PAD && px < ox - PAD + CUR_W && py >= oy - PAD && py < oy - PAD + CUR_H;
      in_inner = px >= ox && px < ox + TEXT_W && py >= oy && py < oy + G_H;
      if (3'(i) == sel && in_outer && !in_inner)
        cursor_hit = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_to_read <= BLANK_ADDR;
      addr_valid   <= 1'b0;
      ovl1         <= 1'b0;
      ovl2         <= 1'b0;
      valid2       <= 1'b0;
      index_out    <= '0;
      index_valid  <= 1'b0;
    end else begin
      addr_to_read <= addr_n;
      addr_valid   <= pix_valid;
      ovl1         <= border_hit || (cursor_hit && blink_on);
      ovl2         <= ovl1;
      valid2       <= addr_valid;
      index_out    <= ovl2 ? BORDER_INDEX : index_in;
      index_valid  <= valid2;
    end
  end

endmodule
